// File: rtl/serial_pkg.sv
// Shared types and constants for the framed serial transmitter.
// Provides the FSM state type, frame bit levels and the bit-counter width helper.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int bit_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_tx_baud_counter.sv
// Modulus-cycles_per_bit_p counter; tick_o is combinational terminal count, zero latency.
// No backpressure: counts whenever en_i is high, clear_i and reset_i force zero.
module baud_counter #(
  parameter int cycles_per_bit_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (cycles_per_bit_p > 1) ? $clog2(cycles_per_bit_p) : 1;
  localparam logic [CW-1:0] LAST = CW'(cycles_per_bit_p - 1);

  logic [CW-1:0] count_q;

  assign tick_o = (count_q == LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= tick_o ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-in framed serial-out transmitter: start bit, LSB-first data, stop bit.
// serial_o goes low the cycle after accept; ready_o is low for the whole frame and new words are ignored.
module serial_tx
  import serial_pkg::*;
#(
  parameter int width_p          = 8,
  parameter int cycles_per_bit_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               serial_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int BW = bit_cnt_w(width_p);
  localparam logic [BW-1:0] LAST_BIT = BW'(width_p - 1);

  tx_state_e          state_q, state_d;
  logic [width_p-1:0] shift_q, shift_d, shift_nxt;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic               serial_q, serial_d;
  logic               done_q, done_d;
  logic               baud_clr;
  logic               tick;

  baud_counter #(
    .cycles_per_bit_p(cycles_per_bit_p)
  ) u_baud (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(baud_clr),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = ~ready_o;
  assign serial_o = serial_q;
  assign done_o   = done_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= STOP_BIT;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
    end
  end

  // serial_d carries the level of the state being entered, so the pin only moves on period ends.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    serial_d  = serial_q;
    done_d    = 1'b0;
    baud_clr  = 1'b0;
    shift_nxt = shift_q >> 1;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d   = START;
          shift_d   = data_i;
          bit_cnt_d = '0;
          serial_d  = START_BIT;
          baud_clr  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d  = DATA;
          serial_d = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d  = STOP;
            serial_d = STOP_BIT;
          end else begin
            serial_d = shift_nxt[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d  = IDLE;
          serial_d = STOP_BIT;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: an 8-bit/4-cycle instance and a 1-bit/1-cycle instance.
module tb_serial_tx;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [7:0] data;
  logic       ready, serial, busy, done;
  logic       valid1;
  logic [0:0] data1;
  logic       ready1, serial1, busy1, done1;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_tx #(.width_p(8), .cycles_per_bit_p(4)) u_dut (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .data_i(data),
    .ready_o(ready), .serial_o(serial), .busy_o(busy), .done_o(done)
  );

  serial_tx #(.width_p(1), .cycles_per_bit_p(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .valid_i(valid1), .data_i(data1),
    .ready_o(ready1), .serial_o(serial1), .busy_o(busy1), .done_o(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: got %0h want %0h", tag, observed, expected);
    end
  endtask

  // Called in the first cycle after an accept edge; returns in the cycle after the stop bit.
  task automatic frame_check(input logic [7:0] w, input string tag, input bit toggle);
    logic exp_bit;
    for (int k = 0; k < 40; k++) begin
      if (k < 4)        exp_bit = 1'b0;
      else if (k >= 36) exp_bit = 1'b1;
      else              exp_bit = w[(k - 4) / 4];
      check($sformatf("%s serial k=%0d", tag, k), {31'b0, serial}, {31'b0, exp_bit});
      check($sformatf("%s ready k=%0d", tag, k), {31'b0, ready}, 32'd0);
      check($sformatf("%s busy k=%0d", tag, k), {31'b0, busy}, 32'd1);
      check($sformatf("%s done k=%0d", tag, k), {31'b0, done}, 32'd0);
      if (toggle) begin
        valid = (k < 38) ? k[0] : 1'b0;
        data  = 8'h00;
      end
      step();
    end
  endtask

  initial begin
    reset  = 1'b1;
    valid  = 1'b0;
    data   = 8'h00;
    valid1 = 1'b0;
    data1  = 1'b0;
    step();
    step();
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      check("idle serial", {31'b0, serial}, 32'd1);
      check("idle ready",  {31'b0, ready},  32'd1);
      check("idle busy",   {31'b0, busy},   32'd0);
      check("idle done",   {31'b0, done},   32'd0);
      check("idle1 serial", {31'b0, serial1}, 32'd1);
      check("idle1 done",   {31'b0, done1},   32'd0);
      step();
    end

    // 2: single frame 0xA5
    valid = 1'b1;
    data  = 8'hA5;
    step();
    valid = 1'b0;
    data  = 8'h00;
    frame_check(8'hA5, "a5", 1'b0);
    check("a5 done pulse", {31'b0, done},   32'd1);
    check("a5 ready back", {31'b0, ready},  32'd1);
    check("a5 busy back",  {31'b0, busy},   32'd0);
    check("a5 idle serial", {31'b0, serial}, 32'd1);
    step();
    check("a5 done drop", {31'b0, done}, 32'd0);
    step();

    // 3: back-to-back with valid held high
    valid = 1'b1;
    data  = 8'h3C;
    step();
    data = 8'hFF;
    frame_check(8'h3C, "3c", 1'b0);
    check("3c done pulse", {31'b0, done},   32'd1);
    check("3c gap serial", {31'b0, serial}, 32'd1);
    check("3c gap ready",  {31'b0, ready},  32'd1);
    step();
    valid = 1'b0;
    frame_check(8'hFF, "ff", 1'b0);
    check("ff done pulse", {31'b0, done}, 32'd1);
    step();
    check("ff done drop", {31'b0, done}, 32'd0);

    // 4: valid/data toggling during frame 0x81 is ignored
    valid = 1'b1;
    data  = 8'h81;
    step();
    valid = 1'b0;
    data  = 8'h00;
    frame_check(8'h81, "81", 1'b1);
    check("81 done pulse", {31'b0, done}, 32'd1);
    step();
    for (int i = 0; i < 6; i++) begin
      check("81 no extra ready",  {31'b0, ready},  32'd1);
      check("81 no extra serial", {31'b0, serial}, 32'd1);
      step();
    end

    // 5: reset during data bit 3 of 0x55
    valid = 1'b1;
    data  = 8'h55;
    step();
    valid = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check("55 bit3 before reset", {31'b0, serial}, 32'd0);
    check("55 busy before reset", {31'b0, busy},   32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst serial", {31'b0, serial}, 32'd1);
    check("rst ready",  {31'b0, ready},  32'd1);
    check("rst done",   {31'b0, done},   32'd0);
    for (int i = 0; i < 40; i++) begin
      check("rst no done", {31'b0, done}, 32'd0);
      step();
    end
    valid = 1'b1;
    data  = 8'h0F;
    step();
    valid = 1'b0;
    frame_check(8'h0F, "0f", 1'b0);
    check("0f done pulse", {31'b0, done}, 32'd1);
    step();

    // 6: width 1, one cycle per bit
    valid1 = 1'b1;
    data1  = 1'b1;
    step();
    valid1 = 1'b0;
    data1  = 1'b0;
    check("w1 start", {31'b0, serial1}, 32'd0);
    check("w1 busy",  {31'b0, busy1},   32'd1);
    step();
    check("w1 data",  {31'b0, serial1}, 32'd1);
    check("w1 data done", {31'b0, done1}, 32'd0);
    step();
    check("w1 stop",  {31'b0, serial1}, 32'd1);
    check("w1 stop busy", {31'b0, busy1}, 32'd1);
    check("w1 stop done", {31'b0, done1}, 32'd0);
    step();
    check("w1 done",  {31'b0, done1},  32'd1);
    check("w1 ready", {31'b0, ready1}, 32'd1);
    step();
    check("w1 done drop", {31'b0, done1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
